fp8_fixed_decoder: RTL

Converts 8-bit floating-point words (sign[7], exponent[6:3], mantissa[2:0]) produced by the FP8 adder back into signed two's-complement fixed-point for downstream integer logic. It is the decode end of the FP8 format the adder emits. It uses an iterative one-bit-per-cycle shifter with valid/ready handshakes on both sides. It sits between the adder's registered output and any consumer needing linear values.

---
 rtl/fp8_pkg.sv | 32 +++
 rtl/fp8_fixed_decoder_if.sv | 24 ++
 rtl/fp8_unpack.sv | 32 +++
 rtl/fp8_fixed_decoder.sv | 107 ++++++++++
 4 files changed

// File: rtl/fp8_pkg.sv
// Shared FP8 format constants, state encoding and sign helper for the FP8 decoder.
// Optional saturation of exponent 15 is enabled with the FP8_DEC_SAT_EN macro.
package fp8_pkg;

  localparam int EXP_W    = 4;
  localparam int MAN_W    = 3;
  localparam int BIAS     = 7;
  localparam int SIGN_POS = 7;
  localparam int EXP_LSB  = 3;
  localparam int MAN_LSB  = 0;

  localparam int FIX_W = 19;
  localparam int FRAC_W = 9;
  localparam int MAG_W = FIX_W - 1;
  localparam int CNT_W = EXP_W;

  // Left shifts needed to place sig at Q9.9: fix = sig * 2^(e - BIAS - MAN_W + FRAC_W).
  localparam int K_OFS = BIAS + MAN_W - FRAC_W;

  localparam logic [FIX_W-1:0] SAT_MAG = 19'h1E000;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  function automatic logic [FIX_W-1:0] apply_sign(input logic s, input logic [FIX_W-1:0] mag);
    return s ? -mag : mag;
  endfunction

endpackage

// File: rtl/fp8_fixed_decoder_if.sv
// Input and output valid/ready channels of the FP8 to Q9.9 decoder.
// Used by fp8_fixed_decoder (slave) and its producer/consumer (master).
interface fp8_fixed_decoder_if;
  import fp8_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_fp;
  logic             out_valid;
  logic             out_ready;
  logic [FIX_W-1:0] out_fix;
  logic             out_ovf;

  modport master (
    output in_valid, in_fp, out_ready,
    input  in_ready, out_valid, out_fix, out_ovf
  );

  modport slave (
    input  in_valid, in_fp, out_ready,
    output in_ready, out_valid, out_fix, out_ovf
  );

endinterface

// File: rtl/fp8_unpack.sv
// Combinational FP8 field splitter: sign, significand with hidden bit, shift count.
// With FP8_DEC_SAT_EN defined, exponent 15 is flagged as special (overflow).
module fp8_unpack
  import fp8_pkg::*;
(
  input  logic [7:0]       i_fp,
  output logic             o_s,
  output logic [MAN_W:0]   o_sig,
  output logic [EXP_W-1:0] o_k,
  output logic             o_is_sub,
  output logic             o_is_special
);

  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_man;

  assign w_exp    = i_fp[EXP_LSB +: EXP_W];
  assign w_man    = i_fp[MAN_LSB +: MAN_W];
  assign o_s      = i_fp[SIGN_POS];
  assign o_is_sub = (w_exp == '0);
  assign o_sig    = {~o_is_sub, w_man};

  // Subnormals share the e=1 scale, so they need no shift at all.
  assign o_k = o_is_sub ? '0 : (w_exp - EXP_W'(K_OFS));

`ifdef FP8_DEC_SAT_EN
  assign o_is_special = (w_exp == '1);
`else
  assign o_is_special = 1'b0;
`endif

endmodule

// File: rtl/fp8_fixed_decoder.sv
// FP8 to signed Q9.9 decoder using a one-bit-per-cycle shifter and valid/ready handshakes.
// FP8_DEC_SAT_EN saturates exponent 15 to +/-240.0 and raises out_ovf.
module fp8_fixed_decoder
  import fp8_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  fp8_fixed_decoder_if.slave bus
);

  state_t           r_state, w_state_nxt;
  logic [MAG_W-1:0] r_mag, w_mag_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_sign, w_sign_nxt;
  logic             r_spec, w_spec_nxt;
  logic [FIX_W-1:0] r_fix, w_fix_nxt;
  logic             r_ovf, w_ovf_nxt;

  logic             w_s;
  logic [MAN_W:0]   w_sig;
  logic [EXP_W-1:0] w_k;
  logic             w_is_sub;
  logic             w_is_special;
  logic             w_accept;

  fp8_unpack u_unpack (
    .i_fp         (bus.in_fp),
    .o_s          (w_s),
    .o_sig        (w_sig),
    .o_k          (w_k),
    .o_is_sub     (w_is_sub),
    .o_is_special (w_is_special)
  );

  assign bus.in_ready  = (r_state == IDLE) && ena;
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_fix   = r_fix;
  assign bus.out_ovf   = r_ovf;

  assign w_accept = bus.in_valid && bus.in_ready;

  // Everything holds while ena is low; DONE keeps its result until the consumer takes it.
  always_comb begin
    w_state_nxt = r_state;
    w_mag_nxt   = r_mag;
    w_cnt_nxt   = r_cnt;
    w_sign_nxt  = r_sign;
    w_spec_nxt  = r_spec;
    w_fix_nxt   = r_fix;
    w_ovf_nxt   = r_ovf;

    if (ena) begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            w_mag_nxt   = MAG_W'(w_sig);
            w_cnt_nxt   = (w_is_sub || w_is_special) ? '0 : w_k;
            w_sign_nxt  = w_s;
            w_spec_nxt  = w_is_special;
            w_state_nxt = SHIFT;
          end
        end
        SHIFT: begin
          if (r_cnt != '0) begin
            w_mag_nxt = {r_mag[MAG_W-2:0], 1'b0};
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end else begin
            w_fix_nxt   = r_spec ? apply_sign(r_sign, SAT_MAG)
                                 : apply_sign(r_sign, {1'b0, r_mag});
            w_ovf_nxt   = r_spec;
            w_state_nxt = DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_mag   <= '0;
      r_cnt   <= '0;
      r_sign  <= 1'b0;
      r_spec  <= 1'b0;
      r_fix   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mag   <= w_mag_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sign  <= w_sign_nxt;
      r_spec  <= w_spec_nxt;
      r_fix   <= w_fix_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

endmodule
